// File: rtl/io_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : io_arb_pkg
// Brief    : Shared types and defaults for the board I/O bus arbiter.
// Revision : 1.0
// ============================================================================
package io_arb_pkg;

    localparam int C_NREQ_DEFAULT = 2;
    localparam int C_AW_DEFAULT   = 16;
    localparam int C_DW_DEFAULT   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Next index after i in a ring of n requesters.
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : io_arbiter_if
// Brief    : Requester handshake bundle plus board I/O slave bus.
//            slave = arbiter view, master = requesters and I/O slave view.
// Revision : 1.0
// ============================================================================
interface io_arbiter_if #(
    parameter int NREQ = io_arb_pkg::C_NREQ_DEFAULT,
    parameter int AW   = io_arb_pkg::C_AW_DEFAULT,
    parameter int DW   = io_arb_pkg::C_DW_DEFAULT
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic [IW-1:0]      owner;

    logic               io_rd;
    logic               io_wr;
    logic [AW-1:0]      io_addr;
    logic [DW-1:0]      io_dout;
    logic [DW-1:0]      io_din;

    modport slave (
        input  req, we, addr, wdata, lock, io_din,
        output ack, rdata, owner, io_rd, io_wr, io_addr, io_dout
    );

    modport master (
        output req, we, addr, wdata, lock, io_din,
        input  ack, rdata, owner, io_rd, io_wr, io_addr, io_dout
    );

endinterface
`default_nettype wire

// File: rtl/io_arbiter_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker; search starts at ptr and wraps.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin : p_pick
        int k;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!valid && req[k]) begin
                valid    = 1'b1;
                grant[k] = 1'b1;
                idx      = IW'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : io_arbiter
// Brief    : Round-robin arbiter sharing the board I/O slave bus between
//            requesters; optional bus lock enabled by IO_ARB_LOCK_EN.
// Revision : 1.0
// ============================================================================
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter int NREQ = C_NREQ_DEFAULT,
    parameter int AW   = C_AW_DEFAULT,
    parameter int DW   = C_DW_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    io_arbiter_if.slave    bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      w_ptr;
    logic [IW-1:0]      w_win;
    logic               w_win_vld;
    logic [NREQ-1:0]    w_req_elig;
    logic [NREQ-1:0]    w_grant;
    logic [NREQ-1:0]    w_owner_oh;

    logic               r_we;
    logic [AW-1:0]      r_io_addr;
    logic [DW-1:0]      r_io_dout;
    logic [DW-1:0]      r_rdata;

    logic [AW-1:0]      w_addr_sel;
    logic [DW-1:0]      w_wdata_sel;
    logic               w_we_sel;

    assign w_owner_oh = NREQ'(1) << r_owner;

`ifdef IO_ARB_LOCK_EN
    logic r_locked;
    logic w_lock_hold;

    // While the owner keeps its lock, only the owner may win and the search
    // starts at the owner so it is picked again.
    assign w_lock_hold = r_locked & (|(bus.lock & w_owner_oh));
    assign w_req_elig  = w_lock_hold ? (bus.req & w_owner_oh) : bus.req;
    assign w_ptr       = w_lock_hold ? r_owner : r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_locked <= 1'b0;
        end else if (r_state == ACK) begin
            r_locked <= |(bus.lock & w_owner_oh);
        end else if ((r_state == IDLE) && !w_lock_hold) begin
            r_locked <= 1'b0;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = ^bus.lock;
    assign w_req_elig    = bus.req;
    assign w_ptr         = r_ptr;
`endif

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req   (w_req_elig),
        .ptr   (w_ptr),
        .grant (w_grant),
        .idx   (w_win),
        .valid (w_win_vld)
    );

    // One-hot AND-OR select of the winner's request fields.
    always_comb begin
        w_addr_sel  = '0;
        w_wdata_sel = '0;
        w_we_sel    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_addr_sel  = w_addr_sel  | bus.addr[i*AW +: AW];
                w_wdata_sel = w_wdata_sel | bus.wdata[i*DW +: DW];
                w_we_sel    = w_we_sel    | bus.we[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_win_vld) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner   <= '0;
            r_ptr     <= '0;
            r_we      <= 1'b0;
            r_io_addr <= '0;
            r_io_dout <= '0;
            r_rdata   <= '0;
        end else begin
            if ((r_state == IDLE) && w_win_vld) begin
                r_owner   <= w_win;
                r_ptr     <= IW'(wrap_inc(int'(w_win), NREQ));
                r_we      <= w_we_sel;
                r_io_addr <= w_addr_sel;
                r_io_dout <= w_wdata_sel;
            end
            // Slave read data is only valid while io_rd is high.
            if ((r_state == ACCESS) && !r_we) begin
                r_rdata <= bus.io_din;
            end
        end
    end

    assign bus.io_rd   = (r_state == ACCESS) & ~r_we;
    assign bus.io_wr   = (r_state == ACCESS) &  r_we;
    assign bus.io_addr = r_io_addr;
    assign bus.io_dout = r_io_dout;
    assign bus.rdata   = r_rdata;
    assign bus.owner   = r_owner;
    assign bus.ack     = (r_state == ACK) ? w_owner_oh : '0;

endmodule
`default_nettype wire

// File: tb/tb_io_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_io_arbiter
// Brief    : Self-checking bench for io_arbiter with a behavioural bus model.
// Revision : 1.0
// ============================================================================
module tb_io_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 16;

    localparam logic [15:0] A_LEDR = 16'h0000;
    localparam logic [15:0] A_LEDG = 16'h0002;
    localparam logic [15:0] A_HEX0 = 16'h0004;
    localparam logic [15:0] A_SW   = 16'h0006;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    io_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) bus ();

    io_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Board I/O slave: 16 registers decoded from io_addr[3:0].
    logic [15:0] slave_mem [0:15];
    logic        pl_en  = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [15:0] pl_dat = 16'd0;

    assign bus.io_din = bus.io_rd ? slave_mem[bus.io_addr[3:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (pl_en) slave_mem[pl_idx] <= pl_dat;
        else if (bus.io_wr) slave_mem[bus.io_addr[3:0]] <= bus.io_dout;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [15:0] dat);
        pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
        step();
        pl_en = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", bus.ack); end
        checks++; if (bus.io_rd !== 1'b0) begin errors++; $display("FAIL reset_io_rd: got %b expected 0", bus.io_rd); end
        checks++; if (bus.io_wr !== 1'b0) begin errors++; $display("FAIL reset_io_wr: got %b expected 0", bus.io_wr); end
        checks++; if (bus.io_addr !== 16'h0) begin errors++; $display("FAIL reset_io_addr: got %h expected 0000", bus.io_addr); end
        checks++; if (bus.io_dout !== 16'h0) begin errors++; $display("FAIL reset_io_dout: got %h expected 0000", bus.io_dout); end
        checks++; if (bus.rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", bus.rdata); end
        checks++; if (bus.owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b expected 0", bus.owner); end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        bus.req[0] = 1'b1; bus.we[0] = 1'b1; bus.lock[0] = 1'b0;
        bus.addr[0 +: AW] = A_LEDG; bus.wdata[0 +: DW] = 16'h00A5;
        checks++; if (bus.io_wr !== 1'b0) begin errors++; $display("FAIL wr_early: got io_wr %b expected 0", bus.io_wr); end
        step();
        checks++; if (bus.io_wr !== 1'b1 || bus.io_rd !== 1'b0) begin errors++; $display("FAIL wr_strobe: got wr %b rd %b expected 1 0", bus.io_wr, bus.io_rd); end
        checks++; if (bus.io_addr !== A_LEDG) begin errors++; $display("FAIL wr_addr: got %h expected %h", bus.io_addr, A_LEDG); end
        checks++; if (bus.io_dout !== 16'h00A5) begin errors++; $display("FAIL wr_dout: got %h expected 00a5", bus.io_dout); end
        checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL wr_ack_early: got %b expected 00", bus.ack); end
        step();
        checks++; if (bus.ack !== 2'b01) begin errors++; $display("FAIL wr_ack: got %b expected 01", bus.ack); end
        checks++; if (bus.io_wr !== 1'b0) begin errors++; $display("FAIL wr_one_cycle: got io_wr %b expected 0", bus.io_wr); end
        checks++; if (bus.io_addr !== A_LEDG || bus.io_dout !== 16'h00A5) begin errors++; $display("FAIL wr_hold: got %h/%h expected %h/00a5", bus.io_addr, bus.io_dout, A_LEDG); end
        bus.req[0] = 1'b0;
        step();
        checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL wr_ack_single: got %b expected 00", bus.ack); end
        checks++; if (slave_mem[2] !== 16'h00A5) begin errors++; $display("FAIL wr_slave: got %h expected 00a5", slave_mem[2]); end
    endtask

    task automatic test_single_read();
        preload(A_SW[3:0], 16'h0155);
        bus.req[1] = 1'b1; bus.we[1] = 1'b0; bus.lock[1] = 1'b0;
        bus.addr[AW +: AW] = A_SW; bus.wdata[DW +: DW] = 16'h0000;
        step();
        checks++; if (bus.io_rd !== 1'b1 || bus.io_wr !== 1'b0) begin errors++; $display("FAIL rd_strobe: got rd %b wr %b expected 1 0", bus.io_rd, bus.io_wr); end
        checks++; if (bus.io_addr !== A_SW) begin errors++; $display("FAIL rd_addr: got %h expected %h", bus.io_addr, A_SW); end
        checks++; if (bus.owner !== 1'b1) begin errors++; $display("FAIL rd_owner: got %b expected 1", bus.owner); end
        step();
        checks++; if (bus.ack !== 2'b10) begin errors++; $display("FAIL rd_ack: got %b expected 10", bus.ack); end
        checks++; if (bus.rdata !== 16'h0155) begin errors++; $display("FAIL rd_data: got %h expected 0155", bus.rdata); end
        checks++; if (bus.io_rd !== 1'b0) begin errors++; $display("FAIL rd_one_cycle: got io_rd %b expected 0", bus.io_rd); end
        bus.req[1] = 1'b0;
        step();
    endtask

    task automatic test_idle_hold();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (bus.io_rd !== 1'b0 || bus.io_wr !== 1'b0 || bus.ack !== 2'b00 || bus.io_addr !== A_SW) begin
                errors++;
                $display("FAIL idle_hold: cycle %0d got rd %b wr %b ack %b addr %h expected 0 0 00 %h",
                         c, bus.io_rd, bus.io_wr, bus.ack, bus.io_addr, A_SW);
            end
            step();
        end
    endtask

    task automatic test_contention();
        int ack_who [$];
        int ack_cyc [$];
        pulse_reset();
        bus.we = 2'b11; bus.lock = 2'b00;
        bus.addr = {A_HEX0, A_LEDR}; bus.wdata = {16'h2222, 16'h1111};
        bus.req = 2'b11;
        for (int c = 1; c <= 20 && ack_who.size() < 4; c++) begin
            step();
            if (bus.ack !== 2'b00) begin
                checks++;
                if (bus.ack === 2'b11) begin errors++; $display("FAIL cont_overlap: got ack %b expected one-hot", bus.ack); end
                ack_who.push_back(bus.ack[1] ? 1 : 0);
                ack_cyc.push_back(c);
            end
        end
        bus.req = 2'b00;
        checks++;
        if (ack_who.size() != 4) begin
            errors++; $display("FAIL cont_count: got %0d acks expected 4", ack_who.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ack_who[k] != (k % 2)) begin errors++; $display("FAIL cont_order: grant %0d got %0d expected %0d", k, ack_who[k], k % 2); end
            end
            checks++; if (ack_cyc[0] != 2) begin errors++; $display("FAIL cont_latency: got cycle %0d expected 2", ack_cyc[0]); end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (ack_cyc[k] - ack_cyc[k-1] != 3) begin errors++; $display("FAIL cont_spacing: got %0d expected 3", ack_cyc[k] - ack_cyc[k-1]); end
            end
        end
        step(); step();
    endtask

    task automatic test_reset_access();
        bus.req[1] = 1'b1; bus.we[1] = 1'b0; bus.addr[AW +: AW] = A_SW;
        step();
        checks++; if (bus.io_rd !== 1'b1) begin errors++; $display("FAIL rst_acc_pre: got io_rd %b expected 1", bus.io_rd); end
        reset = 1'b1;
        step();
        checks++; if (bus.io_rd !== 1'b0 || bus.io_wr !== 1'b0) begin errors++; $display("FAIL rst_acc_strobe: got rd %b wr %b expected 0 0", bus.io_rd, bus.io_wr); end
        checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL rst_acc_ack: got %b expected 00", bus.ack); end
        checks++; if (bus.owner !== 1'b0) begin errors++; $display("FAIL rst_acc_owner: got %b expected 0", bus.owner); end
        reset = 1'b0;
        bus.req = 2'b00;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL rst_acc_noack: got %b expected 00", bus.ack); end
        end
    endtask

    task automatic test_lock();
        int  order [$];
        int  exp_order [3];
        int  n1 = 0;
        bit  raise_pending = 0;
        bit  second_raised = 0;
        bit  lock_cleared  = 0;
`ifdef IO_ARB_LOCK_EN
        exp_order = '{1, 1, 0};
`else
        exp_order = '{1, 0, 1};
`endif
        pulse_reset();
        bus.req[1] = 1'b1; bus.we[1] = 1'b0; bus.lock[1] = 1'b1; bus.addr[AW +: AW] = A_HEX0;
        step();
        bus.req[0] = 1'b1; bus.we[0] = 1'b1; bus.lock[0] = 1'b0;
        bus.addr[0 +: AW] = A_LEDR; bus.wdata[0 +: DW] = 16'h1234;
        for (int c = 0; c < 30 && order.size() < 3; c++) begin
            step();
            if (raise_pending) begin
                bus.req[1] = 1'b1; bus.we[1] = 1'b1; bus.wdata[DW +: DW] = 16'h00FF;
                raise_pending = 0; second_raised = 1;
            end else if (second_raised && !lock_cleared) begin
                bus.lock[1] = 1'b0; lock_cleared = 1;
            end
            if (bus.ack[1] === 1'b1) begin
                order.push_back(1); bus.req[1] = 1'b0; n1++;
                if (n1 == 1) raise_pending = 1;
            end
            if (bus.ack[0] === 1'b1) begin
                order.push_back(0); bus.req[0] = 1'b0;
            end
        end
        bus.req = 2'b00; bus.lock = 2'b00;
        checks++;
        if (order.size() != 3) begin
            errors++; $display("FAIL lock_count: got %0d acks expected 3", order.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (order[k] != exp_order[k]) begin errors++; $display("FAIL lock_order: grant %0d got %0d expected %0d", k, order[k], exp_order[k]); end
            end
        end
        step(); step();
    endtask

    function automatic int pick_rr(input bit act [N], input int start);
        for (int k = 0; k < N; k++) begin
            if (act[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic test_random();
        logic [15:0] ref_mem [16];
        bit          act [N];
        int          phase = 0;
        int          cur = 0;
        int          mptr = 0;
        logic        s_we = 1'b0;
        logic [15:0] s_addr = 16'h0, s_wd = 16'h0, s_rd = 16'h0;
        logic [1:0]  exp_ack;
        logic [3:0]  a4;
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 16'($urandom);
            preload(4'(i), ref_mem[i]);
        end
        for (int i = 0; i < N; i++) act[i] = 0;
        for (int c = 0; c < 600; c++) begin
            if (phase == 1) begin
                checks++;
                if (bus.io_wr !== s_we || bus.io_rd !== !s_we || bus.io_addr !== s_addr || bus.owner !== 1'(cur)) begin
                    errors++;
                    $display("FAIL rnd_strobe: got wr %b rd %b addr %h owner %b expected %b %b %h %0d",
                             bus.io_wr, bus.io_rd, bus.io_addr, bus.owner, s_we, !s_we, s_addr, cur);
                end
                if (s_we) begin
                    checks++;
                    if (bus.io_dout !== s_wd) begin errors++; $display("FAIL rnd_dout: got %h expected %h", bus.io_dout, s_wd); end
                    ref_mem[s_addr[3:0]] = s_wd;
                end else begin
                    s_rd = ref_mem[s_addr[3:0]];
                end
            end else begin
                checks++;
                if (bus.io_rd !== 1'b0 || bus.io_wr !== 1'b0) begin errors++; $display("FAIL rnd_no_strobe: got rd %b wr %b expected 0 0", bus.io_rd, bus.io_wr); end
            end
            exp_ack = (phase == 2) ? (2'b01 << cur) : 2'b00;
            checks++;
            if (bus.ack !== exp_ack) begin errors++; $display("FAIL rnd_ack: got %b expected %b", bus.ack, exp_ack); end
            if (phase == 2) begin
                if (!s_we) begin
                    checks++;
                    if (bus.rdata !== s_rd) begin errors++; $display("FAIL rnd_rdata: got %h expected %h", bus.rdata, s_rd); end
                end
                act[cur] = 0;
                bus.req[cur] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (!act[i] && !(phase == 2 && i == cur) && $urandom_range(0, 2) == 0) begin
                    a4 = 4'($urandom);
                    act[i] = 1;
                    bus.we[i] = 1'($urandom);
                    bus.addr[i*AW +: AW] = {12'h000, a4};
                    bus.wdata[i*DW +: DW] = 16'($urandom);
                    bus.req[i] = 1'b1;
                end
            end
            case (phase)
                0: begin
                    cur = pick_rr(act, mptr);
                    if (cur >= 0) begin
                        mptr   = (cur + 1) % N;
                        s_we   = bus.we[cur];
                        s_addr = bus.addr[cur*AW +: AW];
                        s_wd   = bus.wdata[cur*DW +: DW];
                        phase  = 1;
                    end else begin
                        cur = 0;
                    end
                end
                1: phase = 2;
                default: phase = 0;
            endcase
            step();
        end
        bus.req = 2'b00;
        step(); step(); step();
    endtask

    initial begin
        reset = 1'b1;
        bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_idle_hold();
        test_contention();
        test_reset_access();
        test_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
